// File: rtl/dbtg_pkg.sv
// Shared types and default constants for the push-button debounce / toggle-pulse generator.
package dbtg_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } dbtg_state_e;

  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_RPT_EN     = 1;
  localparam int DEF_RPT_DLY    = 20;
  localparam int DEF_RPT_PER    = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/debounce_toggle_gen.sv
// Debounces a raw push-button and emits single-cycle toggle-enable pulses, with optional auto-repeat.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | button released, waiting for a synchronised press
// PRESS_CHK | counting consecutive pressed samples before accepting
// HELD      | press accepted; initial pulse on entry, repeat timer live
// REL_CHK   | counting consecutive released samples before accepting
module debounce_toggle_gen
  import dbtg_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int RPT_EN     = DEF_RPT_EN,
  parameter int RPT_DLY    = DEF_RPT_DLY,
  parameter int RPT_PER    = DEF_RPT_PER
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic en,
  output logic t_pulse,
  output logic btn_level
);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(RPT_DLY - 1);
  localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(RPT_DLY - RPT_PER);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic             btn_s;
  dbtg_state_e      state, state_nxt;
  logic [CNT_W-1:0] deb_cnt, deb_nxt;
  logic [CNT_W-1:0] rpt_cnt, rpt_nxt;
  logic             t_pulse_nxt, btn_level_nxt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      deb_cnt   <= '0;
      rpt_cnt   <= '0;
      t_pulse   <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      state     <= state_nxt;
      deb_cnt   <= deb_nxt;
      rpt_cnt   <= rpt_nxt;
      t_pulse   <= t_pulse_nxt;
      btn_level <= btn_level_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (btn_s) state_nxt = PRESS_CHK;
      PRESS_CHK: begin
        if (!btn_s)                  state_nxt = IDLE;
        else if (deb_cnt == DEB_LAST) state_nxt = HELD;
      end
      HELD:      if (!btn_s) state_nxt = REL_CHK;
      REL_CHK: begin
        if (btn_s)                    state_nxt = HELD;
        else if (deb_cnt == DEB_LAST) state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    deb_nxt       = '0;
    rpt_nxt       = '0;
    t_pulse_nxt   = 1'b0;
    btn_level_nxt = (state_nxt == HELD) || (state_nxt == REL_CHK);

    if (state_nxt == state) begin
      if ((state == PRESS_CHK && btn_s) || (state == REL_CHK && !btn_s))
        deb_nxt = deb_cnt + 1'b1;
      else
        deb_nxt = deb_cnt;
    end

    // Repeat timer counts only while staying in HELD; any entry restarts it from zero.
    if (state_nxt == HELD) begin
      if (state == PRESS_CHK) begin
        t_pulse_nxt = en;
      end else if (state == HELD) begin
        if ((RPT_EN != 0) && (rpt_cnt == RPT_LAST)) begin
          t_pulse_nxt = en;
          rpt_nxt     = RPT_RELOAD;
        end else if (rpt_cnt != CNT_MAX) begin
          rpt_nxt = rpt_cnt + 1'b1;
        end else begin
          rpt_nxt = rpt_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_debounce_toggle_gen.sv
// Directed bench for debounce_toggle_gen: one instance with auto-repeat, one without, shared stimulus.
module tb_debounce_toggle_gen;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic en;
  logic tp_r, lvl_r;
  logic tp_n, lvl_n;
  logic q_tff = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  debounce_toggle_gen #(
    .DEB_CYCLES (4), .CNT_W (16), .RPT_EN (1), .RPT_DLY (20), .RPT_PER (8)
  ) dut_r (
    .clk (clk), .rst (rst), .btn_in (btn_in), .en (en),
    .t_pulse (tp_r), .btn_level (lvl_r)
  );

  debounce_toggle_gen #(
    .DEB_CYCLES (4), .CNT_W (16), .RPT_EN (0), .RPT_DLY (20), .RPT_PER (8)
  ) dut_n (
    .clk (clk), .rst (rst), .btn_in (btn_in), .en (en),
    .t_pulse (tp_n), .btn_level (lvl_n)
  );

  // Downstream T flip-flop fed by the repeating instance.
  always @(posedge clk) if (tp_r) q_tff <= ~q_tff;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_release();
    btn_in = 1'b0;
    en     = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_in = 1'b0; en = 1'b1;
    tick(); tick();
    total++; if (tp_r !== 1'b0)  begin bad++; $display("FAIL reset_tp_r got=%b want=0", tp_r); end
    total++; if (tp_n !== 1'b0)  begin bad++; $display("FAIL reset_tp_n got=%b want=0", tp_n); end
    total++; if (lvl_r !== 1'b0) begin bad++; $display("FAIL reset_lvl_r got=%b want=0", lvl_r); end
    total++; if (lvl_n !== 1'b0) begin bad++; $display("FAIL reset_lvl_n got=%b want=0", lvl_n); end
    rst = 1'b0;
    repeat (3) tick();
    total++; if (tp_r !== 1'b0 || lvl_r !== 1'b0)
      begin bad++; $display("FAIL idle_after_reset got=%b%b want=00", tp_r, lvl_r); end
  endtask

  task automatic test_clean_press();
    logic exp_tp, exp_lvl;
    btn_in = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      exp_tp  = (c == 7);
      exp_lvl = (c >= 7);
      total++; if (tp_n !== exp_tp)
        begin bad++; $display("FAIL clean_tp_n cyc=%0d got=%b want=%b", c, tp_n, exp_tp); end
      total++; if (tp_r !== exp_tp)
        begin bad++; $display("FAIL clean_tp_r cyc=%0d got=%b want=%b", c, tp_r, exp_tp); end
      total++; if (lvl_n !== exp_lvl)
        begin bad++; $display("FAIL clean_lvl_n cyc=%0d got=%b want=%b", c, lvl_n, exp_lvl); end
    end
    btn_in = 1'b0;
    for (int r = 1; r <= 9; r++) begin
      tick();
      exp_lvl = (r < 7);
      total++; if (lvl_n !== exp_lvl)
        begin bad++; $display("FAIL release_lvl_n cyc=%0d got=%b want=%b", r, lvl_n, exp_lvl); end
      total++; if (lvl_r !== exp_lvl)
        begin bad++; $display("FAIL release_lvl_r cyc=%0d got=%b want=%b", r, lvl_r, exp_lvl); end
      total++; if (tp_n !== 1'b0)
        begin bad++; $display("FAIL release_tp_n cyc=%0d got=%b want=0", r, tp_n); end
    end
    repeat (3) tick();
  endtask

  task automatic test_bounce();
    int pat[7] = '{1, 1, 0, 1, 0, 1, 1};
    logic exp_tp, exp_lvl;
    for (int c = 1; c <= 20; c++) begin
      btn_in = (c <= 7) ? pat[c-1][0] : 1'b1;
      tick();
      exp_tp  = (c == 12);
      exp_lvl = (c >= 12);
      total++; if (tp_r !== exp_tp)
        begin bad++; $display("FAIL bounce_tp_r cyc=%0d got=%b want=%b", c, tp_r, exp_tp); end
      total++; if (lvl_r !== exp_lvl)
        begin bad++; $display("FAIL bounce_lvl_r cyc=%0d got=%b want=%b", c, lvl_r, exp_lvl); end
    end
    do_release();
    total++; if (lvl_r !== 1'b0) begin bad++; $display("FAIL bounce_end_lvl got=%b want=0", lvl_r); end
  endtask

  task automatic test_release_glitch();
    logic exp_tr, exp_tn, exp_lvl;
    for (int c = 1; c <= 36; c++) begin
      btn_in = (c == 11 || c == 12) ? 1'b0 : 1'b1;
      tick();
      exp_tr  = (c == 7) || (c == 35);
      exp_tn  = (c == 7);
      exp_lvl = (c >= 7);
      total++; if (tp_r !== exp_tr)
        begin bad++; $display("FAIL glitch_tp_r cyc=%0d got=%b want=%b", c, tp_r, exp_tr); end
      total++; if (tp_n !== exp_tn)
        begin bad++; $display("FAIL glitch_tp_n cyc=%0d got=%b want=%b", c, tp_n, exp_tn); end
      total++; if (lvl_r !== exp_lvl)
        begin bad++; $display("FAIL glitch_lvl_r cyc=%0d got=%b want=%b", c, lvl_r, exp_lvl); end
    end
    do_release();
    total++; if (lvl_n !== 1'b0) begin bad++; $display("FAIL glitch_end_lvl got=%b want=0", lvl_n); end
  endtask

  task automatic test_auto_repeat();
    logic exp_tr, exp_tn;
    btn_in = 1'b1;
    for (int c = 1; c <= 57; c++) begin
      tick();
      exp_tr = (c == 7) || (c >= 27 && ((c - 27) % 8) == 0);
      exp_tn = (c == 7);
      total++; if (tp_r !== exp_tr)
        begin bad++; $display("FAIL repeat_tp_r cyc=%0d got=%b want=%b", c, tp_r, exp_tr); end
      total++; if (tp_n !== exp_tn)
        begin bad++; $display("FAIL repeat_tp_n cyc=%0d got=%b want=%b", c, tp_n, exp_tn); end
    end
    do_release();
  endtask

  task automatic test_gate();
    logic exp_tr, exp_lvl;
    en = 1'b0;
    btn_in = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      if (c == 33) en = 1'b1;
      tick();
      exp_tr  = (c == 35) || (c == 43);
      exp_lvl = (c >= 7);
      total++; if (tp_r !== exp_tr)
        begin bad++; $display("FAIL gate_tp_r cyc=%0d got=%b want=%b", c, tp_r, exp_tr); end
      total++; if (tp_n !== 1'b0)
        begin bad++; $display("FAIL gate_tp_n cyc=%0d got=%b want=0", c, tp_n); end
      total++; if (lvl_r !== exp_lvl)
        begin bad++; $display("FAIL gate_lvl_r cyc=%0d got=%b want=%b", c, lvl_r, exp_lvl); end
    end
    do_release();
  endtask

  task automatic test_reset_mid_hold();
    logic exp_tp, exp_lvl, q_snap;
    btn_in = 1'b1;
    q_snap = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      tick();
      exp_tp = (c == 7);
      total++; if (tp_r !== exp_tp)
        begin bad++; $display("FAIL midrst_pre_tp cyc=%0d got=%b want=%b", c, tp_r, exp_tp); end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (tp_r !== 1'b0 || tp_n !== 1'b0)
      begin bad++; $display("FAIL midrst_tp got=%b%b want=00", tp_r, tp_n); end
    total++; if (lvl_r !== 1'b0 || lvl_n !== 1'b0)
      begin bad++; $display("FAIL midrst_lvl got=%b%b want=00", lvl_r, lvl_n); end
    for (int d = 1; d <= 9; d++) begin
      tick();
      exp_tp  = (d == 7);
      exp_lvl = (d >= 7);
      if (d == 7) q_snap = q_tff;
      total++; if (tp_r !== exp_tp)
        begin bad++; $display("FAIL midrst_tp_r cyc=%0d got=%b want=%b", d, tp_r, exp_tp); end
      total++; if (tp_n !== exp_tp)
        begin bad++; $display("FAIL midrst_tp_n cyc=%0d got=%b want=%b", d, tp_n, exp_tp); end
      total++; if (lvl_r !== exp_lvl)
        begin bad++; $display("FAIL midrst_lvl_r cyc=%0d got=%b want=%b", d, lvl_r, exp_lvl); end
      if (d >= 8) begin
        total++; if (q_tff !== ~q_snap)
          begin bad++; $display("FAIL tff_q cyc=%0d got=%b want=%b", d, q_tff, ~q_snap); end
      end
    end
    do_release();
  endtask

  initial begin
    rst = 1'b1; btn_in = 1'b0; en = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_auto_repeat();
    test_gate();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
